// File: rtl/tt_um_unsigned_multiplier_seq_if.sv
// Request/result bundle for the sequential shift-add multiplier.
// master drives operands and start; slave returns product, busy and done.
interface tt_um_unsigned_multiplier_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     addend;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    output addend,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    input  addend,
    output product,
    output busy,
    output done
  );
endinterface

// File: rtl/tt_um_unsigned_multiplier_seq.sv
// LSB-first shift-add multiplier: WIDTH RUN cycles, then a one-cycle DONE pulse.
// Define MULT_ADDEND_EN to preload the accumulator with addend (product = A*B + addend).
module tt_um_unsigned_multiplier_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic                          clk,
  input logic                          rst,
  tt_um_unsigned_multiplier_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [2*WIDTH-1:0]   preload;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_iter;

`ifdef MULT_ADDEND_EN
  assign preload = {{WIDTH{1'b0}}, bus.addend};
`else
  // Port kept for a uniform pinout; value is deliberately discarded.
  logic unused_addend;
  assign unused_addend = ^bus.addend;
  assign preload       = '0;
`endif

  assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StRun;
          mcand_d  = {{WIDTH{1'b0}}, bus.multiplicand};
          mplier_d = bus.multiplier;
          acc_d    = preload;
          cnt_d    = '0;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Fixed iteration count: no early exit on small multipliers.
        if (last_iter) begin
          product_d = acc_sum;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);

endmodule
